// File: rtl/pfd_charge_pump.sv
// ---------------------------------------------------------------------------
// pfd_charge_pump
//   Phase-frequency detector and charge pump for the digital PLL model.
//   Rising edges of the reference clock are compared against rising edges of
//   the divided VCO feedback clock. The module drives a signed current towards
//   the loop filter and reports the up/down pulses, the width of the last
//   completed pulse and a lock indicator.
//
// Ports
//   clk                  in   1      system clock, all logic on the rising edge
//   reset                in   1      asynchronous, active-high reset
//   enable               in   1      1 = detector active, 0 = forced IDLE
//   ref_in               in   1      reference clock, asynchronous to clk
//   fb_in                in   1      feedback clock, asynchronous to clk
//   output_current_real  out  CUR_W  signed charge-pump current
//   up                   out  1      high while in UP
//   dn                   out  1      high while in DN
//   pulse_width          out  16     width of the last completed pulse (cycles)
//   lock                 out  1      phase lock indicator
// ---------------------------------------------------------------------------
module pfd_charge_pump #(
  parameter int          CUR_W      = 24,
  parameter int unsigned I_UP       = 32'd2048,
  parameter int unsigned I_DN       = 32'd2048,
  parameter int          RST_CYCLES = 2,
  parameter int          LOCK_WIN   = 4,
  parameter int          LOCK_CNT   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic signed [CUR_W-1:0] output_current_real,
  output logic                    up,
  output logic                    dn,
  output logic [15:0]             pulse_width,
  output logic                    lock
);

  // Current magnitudes clipped to the representable two's complement range.
  localparam longint MAX_POS = (64'sd1 <<< (CUR_W - 1)) - 64'sd1;
  localparam longint NEG_MAG = (64'sd1 <<< (CUR_W - 1));
  localparam longint UP_MAG  = (longint'(I_UP) > MAX_POS) ? MAX_POS : longint'(I_UP);
  localparam longint DN_MAG  = (longint'(I_DN) > NEG_MAG) ? NEG_MAG : longint'(I_DN);
  localparam logic signed [CUR_W-1:0] CUR_UP   = CUR_W'(UP_MAG);
  localparam logic signed [CUR_W-1:0] CUR_DN   = CUR_W'(-DN_MAG);
  localparam logic signed [CUR_W-1:0] CUR_ZERO = CUR_W'(64'sd0);

  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_WIN_W = 16'(LOCK_WIN);
  localparam logic [15:0] LOCK_TGT   = 16'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2,
    ST_RST  = 2'd3
  } state_t;

  // Saturating 16-bit increment used by the width and lock counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Input synchronisers and edge-detect delay flops.
  logic ref_sync1_r, ref_sync2_r, ref_dly_r;
  logic fb_sync1_r, fb_sync2_r, fb_dly_r;
  logic ref_edge_s, fb_edge_s;

  // Control state.
  state_t      state_r, state_next_s;
  logic [15:0] rst_cnt_r;
  logic [15:0] width_cnt_r;
  logic [15:0] width_meas_s;
  logic [15:0] lock_cnt_r, lock_cnt_next_s;
  logic        lock_next_s;
  logic        rst_entry_s;
  logic        in_window_s;

  // Registered outputs.
  logic signed [CUR_W-1:0] current_r, current_next_s;
  logic                    up_r, dn_r, lock_r;
  logic [15:0]             pulse_width_r;

  // Two-flop synchroniser plus delay flop for each asynchronous clock input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_sync1_r <= 1'b0;
      ref_sync2_r <= 1'b0;
      ref_dly_r   <= 1'b0;
      fb_sync1_r  <= 1'b0;
      fb_sync2_r  <= 1'b0;
      fb_dly_r    <= 1'b0;
    end else begin
      ref_sync1_r <= ref_in;
      ref_sync2_r <= ref_sync1_r;
      ref_dly_r   <= ref_sync2_r;
      fb_sync1_r  <= fb_in;
      fb_sync2_r  <= fb_sync1_r;
      fb_dly_r    <= fb_sync2_r;
    end
  end

  assign ref_edge_s = ref_sync2_r & ~ref_dly_r;
  assign fb_edge_s  = fb_sync2_r & ~fb_dly_r;

  // Next-state decode of the detector FSM.
  always_comb begin
    state_next_s = state_r;
    if (!enable) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ref_edge_s && fb_edge_s) begin
            state_next_s = ST_RST;
          end else if (ref_edge_s) begin
            state_next_s = ST_UP;
          end else if (fb_edge_s) begin
            state_next_s = ST_DN;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_UP: begin
          if (fb_edge_s) begin
            state_next_s = ST_RST;
          end else begin
            state_next_s = ST_UP;
          end
        end
        ST_DN: begin
          if (ref_edge_s) begin
            state_next_s = ST_RST;
          end else begin
            state_next_s = ST_DN;
          end
        end
        ST_RST: begin
          // Edges seen here are deliberately ignored: this is the dead zone.
          if (rst_cnt_r >= RST_LAST) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_RST;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Width measured up to and including the current cycle; 0 outside a pulse.
  always_comb begin
    width_meas_s = 16'd0;
    case (state_r)
      ST_UP, ST_DN: width_meas_s = sat_inc16(width_cnt_r);
      default:      width_meas_s = 16'd0;
    endcase
  end

  assign rst_entry_s = (state_next_s == ST_RST) && (state_r != ST_RST);
  assign in_window_s = (width_meas_s <= LOCK_WIN_W);

  // Lock streak update on each completed comparison.
  always_comb begin
    lock_cnt_next_s = lock_cnt_r;
    lock_next_s     = lock_r;
    if (!enable) begin
      lock_cnt_next_s = 16'd0;
      lock_next_s     = 1'b0;
    end else if (rst_entry_s) begin
      if (in_window_s) begin
        if (lock_cnt_r >= LOCK_TGT) begin
          lock_cnt_next_s = LOCK_TGT;
        end else begin
          lock_cnt_next_s = lock_cnt_r + 16'd1;
        end
        lock_next_s = (lock_cnt_next_s >= LOCK_TGT);
      end else begin
        lock_cnt_next_s = 16'd0;
        lock_next_s     = 1'b0;
      end
    end else begin
      lock_cnt_next_s = lock_cnt_r;
      lock_next_s     = lock_r;
    end
  end

  // Charge-pump current selected from the state being entered so it
  // changes on the same edge as the state register.
  always_comb begin
    current_next_s = CUR_ZERO;
    case (state_next_s)
      ST_UP:   current_next_s = CUR_UP;
      ST_DN:   current_next_s = CUR_DN;
      default: current_next_s = CUR_ZERO;
    endcase
  end

  // State register and dead-zone timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rst_cnt_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_RST) && (state_next_s == ST_RST)) begin
        rst_cnt_r <= rst_cnt_r + 16'd1;
      end else begin
        rst_cnt_r <= 16'd0;
      end
    end
  end

  // Pulse width counter and the recorded width of the last comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_cnt_r   <= 16'd0;
      pulse_width_r <= 16'd0;
    end else begin
      if ((state_next_s == ST_UP) || (state_next_s == ST_DN)) begin
        width_cnt_r <= width_meas_s;
      end else begin
        width_cnt_r <= 16'd0;
      end
      if (rst_entry_s) begin
        pulse_width_r <= width_meas_s;
      end else begin
        pulse_width_r <= pulse_width_r;
      end
    end
  end

  // Lock streak counter and lock flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt_r <= 16'd0;
      lock_r     <= 1'b0;
    end else begin
      lock_cnt_r <= lock_cnt_next_s;
      lock_r     <= lock_next_s;
    end
  end

  // Registered current and up/dn decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_r <= CUR_ZERO;
      up_r      <= 1'b0;
      dn_r      <= 1'b0;
    end else begin
      current_r <= current_next_s;
      up_r      <= (state_next_s == ST_UP);
      dn_r      <= (state_next_s == ST_DN);
    end
  end

  assign output_current_real = current_r;
  assign up                  = up_r;
  assign dn                  = dn_r;
  assign pulse_width         = pulse_width_r;
  assign lock                = lock_r;

endmodule

// File: tb/tb_pfd_charge_pump.sv
module tb_pfd_charge_pump;

  localparam int CUR_W      = 24;
  localparam int I_UP       = 2048;
  localparam int I_DN       = 2048;
  localparam int RST_CYCLES = 2;
  localparam int LOCK_WIN   = 4;
  localparam int LOCK_CNT   = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    ref_in;
  logic                    fb_in;
  logic signed [CUR_W-1:0] cur;
  logic                    up;
  logic                    dn;
  logic [15:0]             pw;
  logic                    lock;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pfd_charge_pump #(
    .CUR_W(CUR_W), .I_UP(I_UP), .I_DN(I_DN),
    .RST_CYCLES(RST_CYCLES), .LOCK_WIN(LOCK_WIN), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .output_current_real(cur), .up(up), .dn(dn), .pulse_width(pw), .lock(lock)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, +1 sourcing, -1 sinking, 2 dead zone
  int m_mode, m_dead, m_width, m_last, m_streak;
  bit m_lock;
  bit rh[4];
  bit fh[4];

  task automatic model_reset();
    m_mode = 0; m_dead = 0; m_width = 0; m_last = 0; m_streak = 0; m_lock = 0;
    for (int i = 0; i < 4; i++) begin rh[i] = 0; fh[i] = 0; end
  endtask

  task automatic model_compare(input int w);
    m_last  = w;
    m_mode  = 2;
    m_dead  = RST_CYCLES;
    m_width = 0;
    if (w <= LOCK_WIN) begin
      m_streak = (m_streak + 1 > LOCK_CNT) ? LOCK_CNT : m_streak + 1;
      m_lock   = (m_streak >= LOCK_CNT);
    end else begin
      m_streak = 0;
      m_lock   = 0;
    end
  endtask

  // An input rising seen at edge n-2 acts at edge n.
  task automatic model_step(input bit r, input bit f, input bit e);
    bit re, fe;
    for (int i = 3; i > 0; i--) begin rh[i] = rh[i-1]; fh[i] = fh[i-1]; end
    rh[0] = r; fh[0] = f;
    re = rh[2] & ~rh[3];
    fe = fh[2] & ~fh[3];
    if (!e) begin
      m_mode = 0; m_dead = 0; m_width = 0; m_streak = 0; m_lock = 0;
    end else if (m_mode == 2) begin
      m_dead--;
      if (m_dead == 0) m_mode = 0;
    end else if (m_mode == 0) begin
      if (re && fe)  model_compare(0);
      else if (re)   m_mode = 1;
      else if (fe)   m_mode = -1;
    end else begin
      m_width = (m_width + 1 > 65535) ? 65535 : m_width + 1;
      if ((m_mode == 1 && fe) || (m_mode == -1 && re)) model_compare(m_width);
    end
  endtask

  task automatic check_model();
    int exp_cur;
    exp_cur = (m_mode == 1) ? I_UP : (m_mode == -1) ? -I_DN : 0;
    chk("cur",  longint'(cur), longint'(exp_cur));
    chk("up",   longint'(up), longint'(m_mode == 1));
    chk("dn",   longint'(dn), longint'(m_mode == -1));
    chk("pw",   longint'(pw), longint'(m_last));
    chk("lock", longint'(lock), longint'(m_lock));
  endtask

  task automatic tick(input bit r, input bit f, input bit e);
    @(negedge clk);
    ref_in = r; fb_in = f; enable = e;
    @(posedge clk);
    model_step(r, f, e);
    #1;
    check_model();
  endtask

  task automatic pair(input int ref_t, input int fb_t, input int len);
    for (int t = 0; t < len; t++) tick(bit'(t == ref_t), bit'(t == fb_t), 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cur"},  longint'(cur), 0);
    chk({tag, "_up"},   longint'(up), 0);
    chk({tag, "_dn"},   longint'(dn), 0);
    chk({tag, "_pw"},   longint'(pw), 0);
    chk({tag, "_lock"}, longint'(lock), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ref_in = 1'b0; fb_in = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int ref_at;
    int fb_at;
    int exp_width;
    int exp_up;
    int exp_dn;
    int exp_cur;   // raw 24-bit pattern seen while pulsing
  } vec_t;

  vec_t vecs[6];

  initial begin
    int upc, dnc, seen;
    bit r, f, e;

    vecs[0] = '{0, 10, 10, 10, 0, 2048};
    vecs[1] = '{3,  0,  3,  0, 3, 24'hFFF800};
    vecs[2] = '{0,  0,  0,  0, 0, 0};
    vecs[3] = '{0,  2,  2,  2, 0, 2048};
    vecs[4] = '{5,  0,  5,  0, 5, 24'hFFF800};
    vecs[5] = '{0,  1,  1,  1, 0, 2048};

    reset = 1'b1; enable = 1'b0; ref_in = 1'b0; fb_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b1);

    // Table: step-held inputs with a given phase offset.
    for (int v = 0; v < 6; v++) begin
      int tlen;
      tlen = ((vecs[v].ref_at > vecs[v].fb_at) ? vecs[v].ref_at : vecs[v].fb_at) + 8;
      upc = 0; dnc = 0; seen = 0;
      for (int t = 0; t < tlen; t++) begin
        tick(bit'(t >= vecs[v].ref_at), bit'(t >= vecs[v].fb_at), 1'b1);
        upc += int'(up);
        dnc += int'(dn);
        if (up || dn) seen = int'($unsigned(cur));
      end
      repeat (3) tick(1'b0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_width", v), longint'(pw), longint'(vecs[v].exp_width));
      chk($sformatf("tbl%0d_upcyc", v), longint'(upc), longint'(vecs[v].exp_up));
      chk($sformatf("tbl%0d_dncyc", v), longint'(dnc), longint'(vecs[v].exp_dn));
      chk($sformatf("tbl%0d_cur", v),   longint'(seen), longint'(vecs[v].exp_cur));
    end

    // fb edge lands in the middle of the dead zone and must be dropped.
    pulse_reset();
    upc = 0; dnc = 0;
    for (int t = 0; t < 6; t++) tick(bit'(t == 2), bit'((t == 0) || (t == 3)), 1'b1);
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 1'b0, 1'b1);
      upc += int'(up);
      dnc += int'(dn);
    end
    chk("deadzone_pw", longint'(pw), 2);
    chk("deadzone_no_dn", longint'(dnc), 0);
    chk("deadzone_no_up", longint'(upc), 0);
    chk("deadzone_cur", longint'(cur), 0);

    // Lock acquisition with repeated 2-cycle errors.
    pulse_reset();
    for (int k = 1; k <= LOCK_CNT; k++) begin
      pair(0, 2, 9);
      chk($sformatf("lock_after_%0d", k), longint'(lock), longint'(k >= LOCK_CNT));
    end
    pair(0, 6, 12);
    chk("lock_lost_pw", longint'(pw), 6);
    chk("lock_lost", longint'(lock), 0);
    for (int k = 0; k < LOCK_CNT; k++) pair(2, 0, 9);
    chk("relock", longint'(lock), 1);

    // enable dropped mid-DN.
    tick(1'b0, 1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    chk("dis_dn_before", longint'(dn), 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("dis_cur", longint'(cur), 0);
    chk("dis_lock", longint'(lock), 0);
    chk("dis_dn", longint'(dn), 0);
    repeat (3) tick(1'b0, 1'b0, 1'b1);

    // Async reset mid-UP: outputs clear without a clock edge.
    tick(1'b1, 1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    chk("mid_up_before", longint'(up), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick(1'b0, 1'b0, 1'b1);

    // Randomised waveforms against the model.
    r = 0; f = 0; e = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) r = ~r;
      if ($urandom_range(0, 3) == 0) f = ~f;
      if ($urandom_range(0, 59) == 0) e = 0;
      else if (!e && ($urandom_range(0, 2) == 0)) e = 1;
      tick(r, f, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
